// File: rtl/rr_response_router_if.sv
// rtl/rr_response_router_if.sv - issue, response and per-requester output bundle for rr_response_router
//
// Ports (signals in the bundle):
//   issue_valid / issue_grant / issue_ready : transaction issue from the arbiter side
//   rsp_valid / rsp_data / rsp_ready        : in-order responses from the shared resource
//   out_valid / out_data / out_ready        : one-hot routed response toward the requesters
//   outstanding                             : tag FIFO occupancy
//   err_grant                               : sticky non-one-hot grant flag
// master drives issue, response and out_ready; slave is the router.
interface rr_response_router_if #(
  parameter int INPUTS = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              issue_valid;
  logic [INPUTS-1:0] issue_grant;
  logic              issue_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ready;
  logic [INPUTS-1:0] out_valid;
  logic [DATA_W-1:0] out_data;
  logic [INPUTS-1:0] out_ready;
  logic [CNT_W-1:0]  outstanding;
  logic              err_grant;

  modport master (
    output issue_valid, issue_grant, rsp_valid, rsp_data, out_ready,
    input  issue_ready, rsp_ready, out_valid, out_data, outstanding, err_grant
  );

  modport slave (
    input  issue_valid, issue_grant, rsp_valid, rsp_data, out_ready,
    output issue_ready, rsp_ready, out_valid, out_data, outstanding, err_grant
  );
endinterface

// File: rtl/rr_response_router.sv
// rtl/rr_response_router.sv - routes in-order resource responses back to the requester that issued them
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rr_response_router_if.slave (issue, response, routed output, status)
// Each accepted issue pushes the encoded grant index into a tag FIFO; each
// accepted response pops the head tag and loads a one-entry output stage
// whose one-hot valid points at that requester.
module rr_response_router #(
  parameter int INPUTS = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_response_router_if.slave  bus
);
  localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0]  tag_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              stage_valid;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data_q;
  logic              err_q;

  logic              grant_onehot;
  logic [IDX_W-1:0]  grant_idx;
  logic              issue_ok;
  logic              push;
  logic              bad_grant;
  logic              stage_free;
  logic              rsp_ok;
  logic              pop;
  logic              drain;

  // Explicit wrap so non-power-of-2 depths index only valid entries.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Encoder result is only meaningful when the grant is one-hot.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (bus.issue_grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign grant_onehot = $onehot(bus.issue_grant);

  // No bypass: a full FIFO refuses issues even while a pop is happening.
  assign issue_ok   = (count != CNT_W'(DEPTH));
  assign push       = bus.issue_valid && issue_ok && grant_onehot;
  assign bad_grant  = bus.issue_valid && issue_ok && !grant_onehot;

  // Stage can take a new response if empty or draining this cycle, which
  // lets drain and reload overlap for one response per cycle.
  assign drain      = stage_valid && bus.out_ready[out_idx];
  assign stage_free = !stage_valid || bus.out_ready[out_idx];
  assign rsp_ok     = (count != '0) && stage_free;
  assign pop        = bus.rsp_valid && rsp_ok;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stage_valid <= 1'b0;
      out_idx     <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);

      if (pop) begin
        rd_ptr      <= ptr_inc(rd_ptr);
        out_idx     <= tag_mem[rd_ptr];
        out_data_q  <= bus.rsp_data;
        stage_valid <= 1'b1;
      end else if (drain) begin
        stage_valid <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (bad_grant) err_q <= 1'b1;
    end
  end

  assign bus.issue_ready = issue_ok;
  assign bus.rsp_ready   = rsp_ok;
  assign bus.out_valid   = stage_valid ? (INPUTS'(1) << out_idx) : '0;
  assign bus.out_data    = out_data_q;
  assign bus.outstanding = count;
  assign bus.err_grant   = err_q;
endmodule

// File: tb/tb_rr_response_router.sv
// tb/tb_rr_response_router.sv - scoreboard bench for rr_response_router
module tb_rr_response_router;
  localparam int INPUTS = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
    int         hs_cyc;
    bit         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc_cnt;

  exp_t       exp_q[$];
  logic [1:0] tag_q[$];

  rr_response_router_if #(.INPUTS(INPUTS), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  rr_response_router #(.INPUTS(INPUTS), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Bench-side record of a response handshake: pairs the oldest expected tag with the data.
  task automatic rec_hs(input logic [7:0] d, input bit lat);
    exp_t e;
    if (tag_q.size() == 0) begin
      check("tag_underflow", 1, 0);
    end else begin
      e.idx    = tag_q.pop_front();
      e.data   = d;
      e.hs_cyc = cyc_cnt;
      e.lat    = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] g, input bit exp_ready);
    bus.issue_valid = 1'b1;
    bus.issue_grant = g;
    @(negedge clk);
    check("issue_ready", 32'(bus.issue_ready), 32'(exp_ready));
    if (exp_ready && $onehot(g)) tag_q.push_back(idx_of(g));
    cyc();
    bus.issue_valid = 1'b0;
    bus.issue_grant = '0;
  endtask

  task automatic do_rsp(input logic [7:0] d, input bit lat);
    int n;
    n = 0;
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = d;
    @(negedge clk);
    while (!bus.rsp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_ready) check("rsp_handshake_timeout", 0, 1);
    else rec_hs(d, lat);
    cyc();
    bus.rsp_valid = 1'b0;
  endtask

  // Output monitor: every drain must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((bus.out_valid & bus.out_ready) != '0)) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(bus.out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check("out_valid", 32'(bus.out_valid), 32'(4'b0001 << e.idx));
        check("out_data", 32'(bus.out_data), 32'(e.data));
        if (e.lat) check("latency", cyc_cnt, e.hs_cyc + 1);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc_cnt  = 0;
    rst_n    = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_grant = '0;
    bus.rsp_valid   = 1'b0;
    bus.rsp_data    = '0;
    bus.out_ready   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_outstanding", 32'(bus.outstanding), 0);
    check("rst_rsp_ready", 32'(bus.rsp_ready), 0);
    check("rst_issue_ready", 32'(bus.issue_ready), 1);
    check("rst_err_grant", 32'(bus.err_grant), 0);
    #2 rst_n = 1'b1;
    cyc();

    // Basic routing at full rate
    bus.out_ready = 4'b1111;
    do_issue(4'b0010, 1);
    do_issue(4'b1000, 1);
    do_issue(4'b0001, 1);
    @(negedge clk);
    check("t1_outstanding3", 32'(bus.outstanding), 3);
    cyc();
    do_rsp(8'hA1, 1);
    do_rsp(8'hB2, 1);
    do_rsp(8'hC3, 1);
    repeat (3) cyc();
    check("t1_outstanding0", 32'(bus.outstanding), 0);
    check("t1_drained", exp_q.size(), 0);

    // Fill to DEPTH, refuse 5th, accept it the cycle after a pop
    do_issue(4'b0001, 1);
    do_issue(4'b0010, 1);
    do_issue(4'b0100, 1);
    do_issue(4'b1000, 1);
    do_issue(4'b0001, 0);
    @(negedge clk);
    check("t2_full_outstanding", 32'(bus.outstanding), 4);
    cyc();
    bus.issue_valid = 1'b1;
    bus.issue_grant = 4'b0001;
    bus.rsp_valid   = 1'b1;
    bus.rsp_data    = 8'h11;
    @(negedge clk);
    check("t2_no_bypass_issue_ready", 32'(bus.issue_ready), 0);
    check("t2_pop_rsp_ready", 32'(bus.rsp_ready), 1);
    rec_hs(8'h11, 1);
    cyc();
    bus.rsp_valid = 1'b0;
    @(negedge clk);
    check("t2_after_pop_issue_ready", 32'(bus.issue_ready), 1);
    check("t2_after_pop_outstanding", 32'(bus.outstanding), 3);
    tag_q.push_back(2'd0);
    cyc();
    bus.issue_valid = 1'b0;
    bus.issue_grant = '0;
    @(negedge clk);
    check("t2_refill_outstanding", 32'(bus.outstanding), 4);
    cyc();
    do_rsp(8'h12, 1);
    do_rsp(8'h13, 1);
    do_rsp(8'h14, 1);
    do_rsp(8'h15, 1);
    repeat (3) cyc();
    check("t2_drained", exp_q.size(), 0);

    // Backpressure on requester 2, other ready bits ignored
    bus.out_ready = 4'b0001;
    do_issue(4'b0100, 1);
    do_issue(4'b0001, 1);
    do_rsp(8'h55, 0);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 8'h66;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_out_valid", 32'(bus.out_valid), 32'(4'b0100));
      check("t3_hold_out_data", 32'(bus.out_data), 32'h55);
      check("t3_hold_rsp_ready", 32'(bus.rsp_ready), 0);
      cyc();
    end
    bus.out_ready = 4'b0101;
    @(negedge clk);
    check("t3_reload_rsp_ready", 32'(bus.rsp_ready), 1);
    rec_hs(8'h66, 1);
    cyc();
    bus.rsp_valid = 1'b0;
    bus.out_ready = 4'b1111;
    repeat (3) cyc();
    check("t3_drained", exp_q.size(), 0);

    // Bad grants, sticky error, empty-FIFO response stall
    do_issue(4'b0110, 1);
    @(negedge clk);
    check("t4_multihot_outstanding", 32'(bus.outstanding), 0);
    check("t4_err_set", 32'(bus.err_grant), 1);
    cyc();
    do_issue(4'b0000, 1);
    @(negedge clk);
    check("t4_zero_outstanding", 32'(bus.outstanding), 0);
    check("t4_err_sticky", 32'(bus.err_grant), 1);
    cyc();
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 8'hEE;
    repeat (2) begin
      @(negedge clk);
      check("t4_empty_rsp_ready", 32'(bus.rsp_ready), 0);
      cyc();
    end
    bus.rsp_valid = 1'b0;
    do_issue(4'b0001, 1);
    do_rsp(8'h21, 1);
    repeat (2) cyc();
    check("t4_err_still_set", 32'(bus.err_grant), 1);

    // Simultaneous push and pop at count=2
    do_issue(4'b0010, 1);
    do_issue(4'b0100, 1);
    bus.issue_valid = 1'b1;
    bus.issue_grant = 4'b1000;
    bus.rsp_valid   = 1'b1;
    bus.rsp_data    = 8'h77;
    @(negedge clk);
    check("t5_issue_ready", 32'(bus.issue_ready), 1);
    check("t5_rsp_ready", 32'(bus.rsp_ready), 1);
    tag_q.push_back(2'd3);
    rec_hs(8'h77, 1);
    cyc();
    bus.issue_valid = 1'b0;
    bus.issue_grant = '0;
    bus.rsp_valid   = 1'b0;
    @(negedge clk);
    check("t5_count_unchanged", 32'(bus.outstanding), 2);
    cyc();
    do_rsp(8'h88, 1);
    do_rsp(8'h99, 1);
    repeat (3) cyc();
    check("t5_drained", exp_q.size(), 0);

    // Reset mid-transaction
    bus.out_ready = 4'b0000;
    do_issue(4'b0001, 1);
    do_issue(4'b0010, 1);
    do_issue(4'b0100, 1);
    do_rsp(8'hAA, 0);
    @(negedge clk);
    check("t6_pre_out_valid", 32'(bus.out_valid), 32'(4'b0001));
    check("t6_pre_outstanding", 32'(bus.outstanding), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 32'(bus.out_valid), 0);
    check("t6_rst_out_data", 32'(bus.out_data), 0);
    check("t6_rst_outstanding", 32'(bus.outstanding), 0);
    check("t6_rst_rsp_ready", 32'(bus.rsp_ready), 0);
    check("t6_rst_issue_ready", 32'(bus.issue_ready), 1);
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();
    bus.out_ready = 4'b1111;
    do_issue(4'b1000, 1);
    do_rsp(8'hBB, 1);
    repeat (3) cyc();
    check("t6_drained", exp_q.size(), 0);
    check("t6_outstanding", 32'(bus.outstanding), 0);
    check("t6_tags_left", tag_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
